lsu_ram_ctrl: RTL and testbench
===============================

# lsu_ram_ctrl

Load/store controller between the core's load/store stage and `memory_ram`. It accepts one byte, halfword or word access at a time over a ready/valid handshake and drives the RAM's CE/RD/WR/ADDR/DATA pins. For sub-word stores it performs a read-modify-write, and it returns sign- or zero-extended load data. Misaligned and out-of-range accesses complete with an error and never touch the RAM.

## Interface
- `RAM_ORIGIN`, 32'h100: first valid byte address; must match the RAM instance.
- `RAM_LENGTH`, 32'h08000: valid window size in bytes.
- `iLSU_CLK` in 1: clock, rising edge.
- `iLSU_RST` in 1: reset, asynchronous, active-low.
- `iLSU_REQ` in 1: request valid.
- `oLSU_READY` out 1: controller can accept a request.
- `iLSU_WE` in 1: 1 = store, 0 = load.
- `iLSU_SIZE` in 2: 00 byte, 01 half, 10 word, 11 reserved (error).
- `iLSU_UNSIGNED` in 1: load zero-extends when 1, sign-extends when 0.
- `iLSU_ADDR` in 32: byte address.
- `iLSU_WDATA` in 32: store data, right-aligned.
- `oLSU_VALID` out 1: one-cycle completion pulse.
- `oLSU_RDATA` out 32: load result; 0 for stores and errors.
- `oLSU_ERR` out 1: completion is an error (misaligned, reserved size, or out of range).
- `oRAM_CE`, `oRAM_RD`, `oRAM_WR` out 1 each: RAM controls.
- `oRAM_ADDR` out 32: word-aligned byte address (`addr & ~3`).
- `oRAM_DATA` out 32: RAM write data.
- `iRAM_DATA` in 32: RAM read data. The RAM returns it combinationally in the same cycle as CE&RD.

## Operation
- States are IDLE, RD, RMW_RD, WR and RESP.
- **IDLE:** `oLSU_READY`=1. A request is accepted on a rising edge where REQ&READY=1; address, size, WE, UNSIGNED and WDATA are latched at that edge.
- **Error check at accept:**
  - Error conditions: SIZE=11; half with addr[0]≠0; word with addr[1:0]≠0; addr<RAM_ORIGIN; addr≥RAM_ORIGIN+RAM_LENGTH. Compare in 33 bits so no wrap.
  - On error the controller goes to RESP with ERR=1 and issues no RAM cycle.
- **Next state after a valid accept:**
  - Load → RD.
  - Word store → WR with data = WDATA.
  - Byte or half store → RMW_RD.
- **RD:** CE=RD=1 with ADDR driven. At the edge, latch the extracted and extended lane into RDATA, then go to RESP.
- **RMW_RD:** CE=RD=1. At the edge, latch the merged word (RAM word with the target lane replaced by WDATA[7:0] or [15:0]), then go to WR.
- **WR:** CE=WR=1 with DATA driven; the RAM commits at the edge. Then go to RESP.
- **RESP:** VALID=1 for exactly one cycle, with RDATA/ERR held. Then go to IDLE.
- **Lane rules (little-endian):**
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Sign extension uses bit 7 (byte) or bit 15 (half).
  - A word load ignores UNSIGNED.
- **Outputs outside active states:** RAM controls, ADDR and DATA are 0 in IDLE and RESP.

## Timing
- Reset (async assert) sets: state IDLE, READY=1, VALID=0, ERR=0, RDATA=0, all oRAM_* = 0.
- Reset mid-transaction aborts immediately. WR drops asynchronously, so no partial write occurs, and the pending response is discarded.
- Latency is counted in rising edges after the accept edge until VALID goes high:
  - Error: 1.
  - Load: 2.
  - Word store: 2.
  - Sub-word store: 3.
- READY is 0 from the accept edge until the edge that leaves RESP. A request held through RESP is accepted on the first IDLE edge, giving one bubble cycle between back-to-back transactions.
- REQ is ignored while not in IDLE. The request inputs need only be stable at the accept edge.
- VALID is never asserted for more than one cycle per accepted request. There is exactly one response per accept.

## Structure
- A shared header/package `lsu_defs` holds:
  - state encodings (3-bit);
  - size codes `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - the lane-select constants.
- Sub-module `lsu_lane_align` is purely combinational and handles both directions:
  - load extract/extend: word, addr[1:0], size, unsigned → result;
  - store merge: old word, WDATA, addr[1:0], size → new word.
- The top level contains the FSM, the latches and the range check.

## Test plan
- Word store 0xDEADBEEF to 0x104:
  - WR=1 for exactly one cycle with ADDR=0x104 and DATA=0xDEADBEEF.
  - VALID 2 edges after accept, ERR=0.
  - A word load from 0x104 then returns 0xDEADBEEF.
- Loads from 0x104 after the store above:
  - signed byte at 0x105 → 0xFFFFFFBE;
  - unsigned byte at 0x105 → 0x000000BE;
  - unsigned half at 0x106 → 0x0000DEAD;
  - signed half at 0x106 → 0xFFFFDEAD.
- Byte store 0x55 to 0x107:
  - one RD cycle, then one WR cycle with DATA=0x55ADBEEF;
  - VALID 3 edges after accept;
  - a word load from 0x104 → 0x55ADBEEF.
- Error cases, each giving VALID with ERR=1 one edge after accept and CE never asserted:
  - half load at 0x103;
  - word store at 0x106;
  - SIZE=11;
  - address 0x0FC;
  - address 0x8100.
- Reset asserted during the RMW_RD cycle of a half store to 0x108:
  - all outputs go 0 immediately and READY=1, with no WR ever seen;
  - the RAM word at 0x108 is unchanged;
  - no VALID occurs for the aborted request.
- REQ held high continuously for 3 word loads: exactly 3 VALID pulses, each separated by one idle bubble, with correct data each time.

Source files
------------

// File: rtl/lsu_defs.sv
// Shared definitions for the load/store RAM controller: FSM state encoding, access size codes
// and lane-select constants.
package lsu_defs;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRd    = 3'd1,
    StRmwRd = 3'd2,
    StWr    = 3'd3,
    StResp  = 3'd4
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;
  localparam logic       HALF_LO = 1'b0;
  localparam logic       HALF_HI = 1'b1;

endpackage

// File: rtl/lsu_ram_ctrl_if.sv
// Core-side request/response bus of the load/store RAM controller.
interface lsu_ram_ctrl_if;
  logic        iLSU_REQ;
  logic        oLSU_READY;
  logic        iLSU_WE;
  logic [1:0]  iLSU_SIZE;
  logic        iLSU_UNSIGNED;
  logic [31:0] iLSU_ADDR;
  logic [31:0] iLSU_WDATA;
  logic        oLSU_VALID;
  logic [31:0] oLSU_RDATA;
  logic        oLSU_ERR;

  modport master (
    output iLSU_REQ, iLSU_WE, iLSU_SIZE, iLSU_UNSIGNED, iLSU_ADDR, iLSU_WDATA,
    input  oLSU_READY, oLSU_VALID, oLSU_RDATA, oLSU_ERR
  );

  modport slave (
    input  iLSU_REQ, iLSU_WE, iLSU_SIZE, iLSU_UNSIGNED, iLSU_ADDR, iLSU_WDATA,
    output oLSU_READY, oLSU_VALID, oLSU_RDATA, oLSU_ERR
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: load extract/extend and sub-word store merge (combinational).
module lsu_lane_align
  import lsu_defs::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    unique case (offset_i)
      LANE_B0: byte_sel = word_i[7:0];
      LANE_B1: byte_sel = word_i[15:8];
      LANE_B2: byte_sel = word_i[23:16];
      LANE_B3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = (offset_i[1] == HALF_HI) ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    load_o = word_i;
    unique case (size_i)
      SZ_BYTE: load_o = unsigned_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_o = unsigned_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_o = word_i;
    endcase
  end

  always_comb begin
    merge_o = word_i;
    unique case (size_i)
      SZ_BYTE: begin
        unique case (offset_i)
          LANE_B0: merge_o[7:0]   = wdata_i[7:0];
          LANE_B1: merge_o[15:8]  = wdata_i[7:0];
          LANE_B2: merge_o[23:16] = wdata_i[7:0];
          LANE_B3: merge_o[31:24] = wdata_i[7:0];
          default: merge_o        = word_i;
        endcase
      end
      SZ_HALF: begin
        if (offset_i[1] == HALF_LO) merge_o[15:0]  = wdata_i[15:0];
        else                        merge_o[31:16] = wdata_i[15:0];
      end
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ram_ctrl.sv
// Load/store controller driving a single-cycle RAM: one access at a time, read-modify-write
// for sub-word stores, error completion for misaligned or out-of-window accesses.
module lsu_ram_ctrl
  import lsu_defs::*;
#(
  parameter logic [31:0] RAM_ORIGIN = 32'h100,
  parameter logic [31:0] RAM_LENGTH = 32'h08000
) (
  input  logic        iLSU_CLK,
  input  logic        iLSU_RST,
  lsu_ram_ctrl_if.slave lsu,
  output logic        oRAM_CE,
  output logic        oRAM_RD,
  output logic        oRAM_WR,
  output logic [31:0] oRAM_ADDR,
  output logic [31:0] oRAM_DATA,
  input  logic [31:0] iRAM_DATA
);

  // 33-bit window bounds so origin+length cannot wrap.
  localparam logic [32:0] OriginExt = {1'b0, RAM_ORIGIN};
  localparam logic [32:0] EndExt    = {1'b0, RAM_ORIGIN} + {1'b0, RAM_LENGTH};

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        acc_err;
  logic        misalign;
  logic [32:0] req_addr_ext;
  logic [31:0] load_word;
  logic [31:0] merge_word;

  lsu_lane_align u_lane_align (
    .word_i     (iRAM_DATA),
    .wdata_i    (wdata_q),
    .offset_i   (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .load_o     (load_word),
    .merge_o    (merge_word)
  );

  always_comb begin
    req_addr_ext = {1'b0, lsu.iLSU_ADDR};
    misalign     = 1'b0;
    unique case (lsu.iLSU_SIZE)
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = lsu.iLSU_ADDR[0];
      SZ_WORD: misalign = |lsu.iLSU_ADDR[1:0];
      SZ_RSVD: misalign = 1'b1;
      default: misalign = 1'b1;
    endcase
    acc_err = misalign || (req_addr_ext < OriginExt) || (req_addr_ext >= EndExt);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (lsu.iLSU_REQ) begin
          addr_d  = lsu.iLSU_ADDR;
          size_d  = lsu.iLSU_SIZE;
          we_d    = lsu.iLSU_WE;
          uns_d   = lsu.iLSU_UNSIGNED;
          wdata_d = lsu.iLSU_WDATA;
          rdata_d = '0;
          err_d   = acc_err;
          if (acc_err)                        state_d = StResp;
          else if (!lsu.iLSU_WE)              state_d = StRd;
          else if (lsu.iLSU_SIZE == SZ_WORD)  state_d = StWr;
          else                                state_d = StRmwRd;
        end
      end
      StRd: begin
        rdata_d = load_word;
        state_d = StResp;
      end
      StRmwRd: begin
        wdata_d = merge_word;
        state_d = StWr;
      end
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iLSU_CLK or negedge iLSU_RST) begin
    if (!iLSU_RST) begin
      state_q <= StIdle;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode straight from the state register so reset drops them asynchronously.
  always_comb begin
    lsu.oLSU_READY = (state_q == StIdle);
    lsu.oLSU_VALID = (state_q == StResp);
    lsu.oLSU_RDATA = rdata_q;
    lsu.oLSU_ERR   = err_q;
    oRAM_CE        = 1'b0;
    oRAM_RD        = 1'b0;
    oRAM_WR        = 1'b0;
    oRAM_ADDR      = '0;
    oRAM_DATA      = '0;
    unique case (state_q)
      StRd, StRmwRd: begin
        oRAM_CE   = 1'b1;
        oRAM_RD   = 1'b1;
        oRAM_ADDR = {addr_q[31:2], 2'b00};
      end
      StWr: begin
        oRAM_CE   = 1'b1;
        oRAM_WR   = 1'b1;
        oRAM_ADDR = {addr_q[31:2], 2'b00};
        oRAM_DATA = wdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_ram_ctrl.sv
// Self-checking bench for lsu_ram_ctrl: table of accesses against a behavioural RAM, with a
// response scoreboard, plus reset-abort and back-to-back sequences.
module tb_lsu_ram_ctrl;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          ce;
    int          wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ram_ce, ram_rd, ram_wr;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [12:0] widx;
  logic [31:0] mem [0:8191];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ce_n = 0;
  int wr_n = 0;
  int wr_tot = 0;
  int valid_tot = 0;
  logic [31:0] wr_a = '0;
  logic [31:0] wr_d = '0;
  exp_t q[$];

  lsu_ram_ctrl_if lsu ();

  lsu_ram_ctrl #(
    .RAM_ORIGIN (32'h100),
    .RAM_LENGTH (32'h08000)
  ) u_dut (
    .iLSU_CLK  (clk),
    .iLSU_RST  (rst_n),
    .lsu       (lsu),
    .oRAM_CE   (ram_ce),
    .oRAM_RD   (ram_rd),
    .oRAM_WR   (ram_wr),
    .oRAM_ADDR (ram_addr),
    .oRAM_DATA (ram_wdata),
    .iRAM_DATA (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural memory_ram: combinational read, write at the rising edge.
  assign widx = 13'((ram_addr - 32'h100) >> 2);
  always_comb begin
    ram_rdata = '0;
    if (ram_ce && ram_rd) ram_rdata = mem[widx];
  end
  always @(posedge clk) begin
    if (ram_ce && ram_wr) mem[widx] <= ram_wdata;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor / scoreboard consumer.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      ce_n = 0;
      wr_n = 0;
    end else begin
      if (ram_ce) ce_n++;
      if (ram_wr) begin
        wr_n++;
        wr_tot++;
        wr_a = ram_addr;
        wr_d = ram_wdata;
      end
      if (lsu.oLSU_VALID) begin
        exp_t e;
        valid_tot++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got VALID=1 expected no response (cyc %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk($sformatf("v%0d_rdata", e.id), lsu.oLSU_RDATA, e.rdata);
          chk($sformatf("v%0d_err", e.id), 32'(lsu.oLSU_ERR), 32'(e.err));
          chk($sformatf("v%0d_latency", e.id), 32'(cyc - e.acc + 1), 32'(e.lat));
          chk($sformatf("v%0d_ce_cycles", e.id), 32'(ce_n), 32'(e.ce));
          chk($sformatf("v%0d_wr_cycles", e.id), 32'(wr_n), 32'(e.wr));
          if (e.wr != 0) begin
            chk($sformatf("v%0d_wr_addr", e.id), wr_a, e.waddr);
            chk($sformatf("v%0d_wr_data", e.id), wr_d, e.wdata);
          end
        end
        ce_n = 0;
        wr_n = 0;
      end
    end
  end

  task automatic issue(input int id, input vec_t v, input bit hold, output int acc);
    exp_t e;
    int   t = 0;
    @(negedge clk);
    while (!lsu.oLSU_READY && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!lsu.oLSU_READY) chk($sformatf("v%0d_ready_timeout", id), 32'(lsu.oLSU_READY), 32'd1);
    lsu.iLSU_REQ      = 1'b1;
    lsu.iLSU_WE       = v.we;
    lsu.iLSU_SIZE     = v.size;
    lsu.iLSU_UNSIGNED = v.uns;
    lsu.iLSU_ADDR     = v.addr;
    lsu.iLSU_WDATA    = v.wdata;
    e.id    = id;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    e.lat   = v.exp_lat;
    e.ce    = v.exp_lat - 1;
    e.wr    = (v.we && !v.exp_err) ? 1 : 0;
    e.waddr = {v.addr[31:2], 2'b00};
    e.wdata = v.exp_wdata;
    e.acc   = cyc + 1;
    acc     = e.acc;
    q.push_back(e);
    @(posedge clk);
    if (!hold) begin
      #1 lsu.iLSU_REQ = 1'b0;
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while (q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      chk("response_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, 32'(lsu.oLSU_READY), 32'd1);
    chk({tag, "_valid"}, 32'(lsu.oLSU_VALID), 32'd0);
    chk({tag, "_err"}, 32'(lsu.oLSU_ERR), 32'd0);
    chk({tag, "_rdata"}, lsu.oLSU_RDATA, 32'd0);
    chk({tag, "_ram_ctl"}, {29'd0, ram_ce, ram_rd, ram_wr}, 32'd0);
    chk({tag, "_ram_addr"}, ram_addr, 32'd0);
    chk({tag, "_ram_data"}, ram_wdata, 32'd0);
  endtask

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

  vec_t tbl[23];

  initial begin
    int a1, a2, a3, acc, wr_snap, val_snap;
    vec_t v;

    tbl[0]  = '{1'b1, W, 1'b0, 32'h104,  32'hDEADBEEF, 32'h0,        1'b0, 2, 32'hDEADBEEF};
    tbl[1]  = '{1'b0, W, 1'b1, 32'h104,  32'h0,        32'hDEADBEEF, 1'b0, 2, 32'h0};
    tbl[2]  = '{1'b0, B, 1'b0, 32'h105,  32'h0,        32'hFFFFFFBE, 1'b0, 2, 32'h0};
    tbl[3]  = '{1'b0, B, 1'b1, 32'h105,  32'h0,        32'h000000BE, 1'b0, 2, 32'h0};
    tbl[4]  = '{1'b0, H, 1'b1, 32'h106,  32'h0,        32'h0000DEAD, 1'b0, 2, 32'h0};
    tbl[5]  = '{1'b0, H, 1'b0, 32'h106,  32'h0,        32'hFFFFDEAD, 1'b0, 2, 32'h0};
    tbl[6]  = '{1'b1, B, 1'b0, 32'h107,  32'hAAAAAA55, 32'h0,        1'b0, 3, 32'h55ADBEEF};
    tbl[7]  = '{1'b0, W, 1'b0, 32'h104,  32'h0,        32'h55ADBEEF, 1'b0, 2, 32'h0};
    tbl[8]  = '{1'b1, H, 1'b0, 32'h106,  32'hCCCC7777, 32'h0,        1'b0, 3, 32'h7777BEEF};
    tbl[9]  = '{1'b0, W, 1'b0, 32'h104,  32'h0,        32'h7777BEEF, 1'b0, 2, 32'h0};
    tbl[10] = '{1'b0, H, 1'b0, 32'h104,  32'h0,        32'hFFFFBEEF, 1'b0, 2, 32'h0};
    tbl[11] = '{1'b0, B, 1'b0, 32'h104,  32'h0,        32'hFFFFFFEF, 1'b0, 2, 32'h0};
    tbl[12] = '{1'b0, B, 1'b0, 32'h106,  32'h0,        32'h00000077, 1'b0, 2, 32'h0};
    tbl[13] = '{1'b1, W, 1'b0, 32'h80FC, 32'hA5A50001, 32'h0,        1'b0, 2, 32'hA5A50001};
    tbl[14] = '{1'b0, H, 1'b1, 32'h80FE, 32'h0,        32'h0000A5A5, 1'b0, 2, 32'h0};
    tbl[15] = '{1'b1, W, 1'b0, 32'h108,  32'hCAFEF00D, 32'h0,        1'b0, 2, 32'hCAFEF00D};
    tbl[16] = '{1'b0, H, 1'b0, 32'h103,  32'h0,        32'h0,        1'b1, 1, 32'h0};
    tbl[17] = '{1'b1, W, 1'b0, 32'h106,  32'h11111111, 32'h0,        1'b1, 1, 32'h0};
    tbl[18] = '{1'b0, R, 1'b0, 32'h104,  32'h0,        32'h0,        1'b1, 1, 32'h0};
    tbl[19] = '{1'b0, W, 1'b0, 32'h0FC,  32'h0,        32'h0,        1'b1, 1, 32'h0};
    tbl[20] = '{1'b0, W, 1'b0, 32'h8100, 32'h0,        32'h0,        1'b1, 1, 32'h0};
    tbl[21] = '{1'b0, B, 1'b0, 32'h80FF, 32'h0,        32'hFFFFFFA5, 1'b0, 2, 32'h0};
    tbl[22] = '{1'b1, B, 1'b0, 32'h0FF,  32'h11111111, 32'h0,        1'b1, 1, 32'h0};

    lsu.iLSU_REQ      = 1'b0;
    lsu.iLSU_WE       = 1'b0;
    lsu.iLSU_SIZE     = 2'b00;
    lsu.iLSU_UNSIGNED = 1'b0;
    lsu.iLSU_ADDR     = '0;
    lsu.iLSU_WDATA    = '0;
    repeat (2) @(posedge clk);
    #1 check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      issue(i, tbl[i], 1'b0, acc);
      wait_done();
    end

    // Reset during the read half of a half store to 0x108: no write, no response.
    wr_snap  = wr_tot;
    val_snap = valid_tot;
    @(negedge clk);
    lsu.iLSU_REQ   = 1'b1;
    lsu.iLSU_WE    = 1'b1;
    lsu.iLSU_SIZE  = H;
    lsu.iLSU_ADDR  = 32'h108;
    lsu.iLSU_WDATA = 32'h00001234;
    @(posedge clk);
    #1 lsu.iLSU_REQ = 1'b0;
    chk("rmw_rd_active", {29'd0, ram_ce, ram_rd, ram_wr}, 32'd6);
    #1 rst_n = 1'b0;
    #1 check_idle_outputs("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_wr", 32'(wr_tot - wr_snap), 32'd0);
    chk("abort_no_valid", 32'(valid_tot - val_snap), 32'd0);
    v = '{1'b0, W, 1'b0, 32'h108, 32'h0, 32'hCAFEF00D, 1'b0, 2, 32'h0};
    issue(100, v, 1'b0, acc);
    wait_done();

    // REQ held high across three word loads.
    val_snap = valid_tot;
    v = '{1'b0, W, 1'b0, 32'h104, 32'h0, 32'h7777BEEF, 1'b0, 2, 32'h0};
    issue(200, v, 1'b1, a1);
    v = '{1'b0, W, 1'b0, 32'h80FC, 32'h0, 32'hA5A50001, 1'b0, 2, 32'h0};
    issue(201, v, 1'b1, a2);
    v = '{1'b0, W, 1'b0, 32'h108, 32'h0, 32'hCAFEF00D, 1'b0, 2, 32'h0};
    issue(202, v, 1'b1, a3);
    #1 lsu.iLSU_REQ = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    chk("b2b_spacing_1", 32'(a2 - a1), 32'd3);
    chk("b2b_spacing_2", 32'(a3 - a2), 32'd3);
    chk("b2b_valid_count", 32'(valid_tot - val_snap), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
